// File: rtl/pos_embed_stream.sv
// Purpose: latch a patch-embedding frame, prepend the CLS row, add positional embeddings with saturation, stream rows.
// Latency: first row valid 1 cycle after emb_done; one row per beat with no bubbles; frame_done 1 cycle after the last beat.
// Backpressure: out_row/out_idx/out_last hold while out_ready is low; emb_done while streaming is dropped and flagged in overrun.
module pos_embed_stream #(
  parameter int N_PATCH = 15,
  parameter int D_MODEL = 16,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] emb       [N_PATCH][D_MODEL],
  input  logic         emb_done,
  input  logic [W-1:0] cls_token [D_MODEL],
  input  logic [W-1:0] pos_emb   [N_PATCH+1][D_MODEL],
  output logic [W-1:0] out_row   [D_MODEL],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_idx,
  output logic         out_last,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  localparam int IW = $clog2(N_PATCH + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] row_q [D_MODEL];
  logic [W-1:0] row_d [D_MODEL];
  logic [W-1:0] buf_q [N_PATCH][D_MODEL];
  logic [W-1:0] buf_d [N_PATCH][D_MODEL];
  logic [4:0]   idx_q, idx_d;
  logic         vld_q, vld_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic         fdone_q, fdone_d;
  logic         ovr_q, ovr_d;
  logic         hs;
  logic         load_frame;
  logic [IW-1:0] cur;
  logic [IW-1:0] nxt;

  // Sign-extend to W+1 bits, add, clamp when the two top bits disagree.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  // Next-state: row advance on handshake, frame end / back-to-back reload, overrun detection.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    last_d     = last_q;
    busy_d     = busy_q;
    fdone_d    = 1'b0;
    ovr_d      = ovr_q;
    load_frame = 1'b0;
    hs         = vld_q && out_ready;
    cur        = idx_q[IW-1:0];
    nxt        = cur + IW'(1);

    case (state_q)
      IDLE: begin
        if (emb_done) load_frame = 1'b1;
      end
      STREAM: begin
        // A new frame is only accepted in the same cycle the final row leaves.
        if (emb_done && !(hs && last_q)) ovr_d = 1'b1;
        if (hs) begin
          if (!last_q) begin
            for (int j = 0; j < D_MODEL; j++) row_d[j] = sat_add(buf_q[cur][j], pos_emb[nxt][j]);
            idx_d  = idx_q + 5'd1;
            last_d = ((idx_q + 5'd1) == 5'(N_PATCH));
          end else begin
            fdone_d = 1'b1;
            if (emb_done) begin
              load_frame = 1'b1;
            end else begin
              state_d = IDLE;
              vld_d   = 1'b0;
              busy_d  = 1'b0;
              last_d  = 1'b0;
              idx_d   = 5'd0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_frame) begin
      buf_d = emb;
      for (int j = 0; j < D_MODEL; j++) row_d[j] = sat_add(cls_token[j], pos_emb[0][j]);
      idx_d   = 5'd0;
      vld_d   = 1'b1;
      last_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = STREAM;
    end
  end

  // FSM state and all registered outputs; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '{default: '0};
      idx_q   <= 5'd0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame buffer needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_row    = row_q;
  assign out_valid  = vld_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pos_embed_stream.sv
module tb_pos_embed_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] emb       [15][16];
  logic       emb_done;
  logic [7:0] cls_token [16];
  logic [7:0] pos_emb   [16][16];
  logic [7:0] out_row   [16];
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  typedef struct packed {
    logic [4:0]   idx;
    logic         last;
    logic [127:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pos_embed_stream dut (
    .clk(clk), .rst(rst), .emb(emb), .emb_done(emb_done),
    .cls_token(cls_token), .pos_emb(pos_emb), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  function automatic logic [7:0] msat(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = $signed(a) + $signed(b);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [127:0] flat_out();
    logic [127:0] f;
    for (int j = 0; j < 16; j++) f[8*j +: 8] = out_row[j];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected rows for a frame, snapshotting the bench's current emb/cls/pos.
  task automatic push_frame();
    exp_t e;
    e.idx  = 5'd0;
    e.last = 1'b0;
    for (int j = 0; j < 16; j++) e.row[8*j +: 8] = msat(cls_token[j], pos_emb[0][j]);
    exp_q.push_back(e);
    for (int r = 1; r <= 15; r++) begin
      e.idx  = 5'(r);
      e.last = (r == 15);
      for (int j = 0; j < 16; j++) e.row[8*j +: 8] = msat(emb[r-1][j], pos_emb[r][j]);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_frame();
    tick();
    push_frame();
    emb_done = 1'b1;
    tick();
    emb_done = 1'b0;
  endtask

  task automatic wait_idx(input logic [4:0] target, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == target) seen = 1'b1;
    end
    chk(nm, 128'(seen), 128'(1));
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk(nm, 128'(seen), 128'(1));
  endtask

  task automatic set_uniform(input logic [7:0] e, input logic [7:0] c, input logic [7:0] p);
    for (int r = 0; r < 15; r++) for (int j = 0; j < 16; j++) emb[r][j] = e;
    for (int j = 0; j < 16; j++) cls_token[j] = c;
    for (int r = 0; r < 16; r++) for (int j = 0; j < 16; j++) pos_emb[r][j] = p;
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected row.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got idx %0d with no expected row", out_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_beat", {out_idx, out_last, flat_out()}, {e.idx, e.last, e.row});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    emb_done  = 1'b0;
    out_ready = 1'b1;
    set_uniform(8'h10, 8'h08, 8'h01);

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_outs", {123'd0, out_valid, out_last, busy, frame_done, overrun}, 128'd0);
    chk("rst_idx", 128'(out_idx), 128'd0);
    chk("rst_row", flat_out(), 128'd0);
    tick();
    rst = 1'b0;

    // Basic frame with exact cycle timing
    issue_frame();
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      if (k <= 16) begin
        chk("basic_vld_idx", {out_valid, busy, out_last, out_idx}, {1'b1, 1'b1, (k == 16), 5'(k - 1)});
        if (k == 1) chk("basic_row0", flat_out(), {16{8'h09}});
        if (k == 2) chk("basic_row1", flat_out(), {16{8'h11}});
      end else begin
        chk("basic_end", {frame_done, busy, out_valid}, {1'b1, 1'b0, 1'b0});
      end
    end
    chk("basic_sb_empty", 128'(exp_q.size()), 128'd0);

    // Saturation in row 1
    emb[0][0] = 8'h70; pos_emb[1][0] = 8'h20;
    emb[0][1] = 8'h90; pos_emb[1][1] = 8'hE0;
    emb[0][2] = 8'h40; pos_emb[1][2] = 8'hC0;
    issue_frame();
    wait_idx(5'd1, "sat_reach_idx1");
    chk("sat_elems", {out_row[2], out_row[1], out_row[0], out_row[3]}, {8'h00, 8'h80, 8'h7F, 8'h11});
    wait_done("sat_done");
    chk("sat_sb_empty", 128'(exp_q.size()), 128'd0);
    set_uniform(8'h10, 8'h08, 8'h01);
    for (int r = 0; r < 15; r++) emb[r][0] = 8'(8'h20 + r);

    // Backpressure: out_ready low in cycles 3..7
    issue_frame();
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      out_ready = !(k >= 3 && k <= 7);
      @(negedge clk);
      if (k >= 3 && k <= 8) chk("bp_hold", {out_valid, out_idx, flat_out()}, {1'b1, 5'd2, exp_q[0].row});
      if (k == 9) chk("bp_idx3", {out_valid, out_idx}, {1'b1, 5'd3});
    end
    wait_done("bp_done");
    chk("bp_sb_empty", 128'(exp_q.size()), 128'd0);

    // Overrun: second emb_done at cycle 5 is dropped
    issue_frame();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      if (k == 5) begin
        emb_done = 1'b1;
        for (int r = 0; r < 15; r++) for (int j = 0; j < 16; j++) emb[r][j] = 8'h33;
      end
      if (k == 6) emb_done = 1'b0;
      @(negedge clk);
      if (k == 5) chk("ovr_before", 128'(overrun), 128'd0);
      if (k == 6) chk("ovr_set", 128'(overrun), 128'd1);
    end
    wait_done("ovr_done");
    chk("ovr_end", {overrun, busy, out_valid}, {1'b1, 1'b0, 1'b0});
    chk("ovr_sb_empty", 128'(exp_q.size()), 128'd0);
    set_uniform(8'h10, 8'h08, 8'h01);

    // Reset mid-stream at idx 7
    issue_frame();
    wait_idx(5'd7, "rst_reach_idx7");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_outs", {out_valid, out_last, busy, frame_done, overrun, out_idx}, 10'd0);
    chk("mid_rst_row", flat_out(), 128'd0);
    tick();
    @(negedge clk);
    chk("mid_rst_no_fdone", 128'(frame_done), 128'd0);
    for (int r = 0; r < 15; r++) for (int j = 0; j < 16; j++) emb[r][j] = 8'(r * 3 + j);
    issue_frame();
    @(negedge clk);
    chk("fresh_idx0", {out_valid, out_idx, flat_out()}, {1'b1, 5'd0, {16{8'h09}}});
    wait_done("fresh_done");
    chk("fresh_sb_empty", 128'(exp_q.size()), 128'd0);

    // Back-to-back: new emb_done coincident with the idx-15 handshake
    issue_frame();
    wait_idx(5'd15, "b2b_reach_idx15");
    for (int r = 0; r < 15; r++) for (int j = 0; j < 16; j++) emb[r][j] = 8'h22;
    for (int j = 0; j < 16; j++) cls_token[j] = 8'h20;
    push_frame();
    emb_done = 1'b1;
    tick();
    emb_done = 1'b0;
    @(negedge clk);
    chk("b2b_flags", {frame_done, out_valid, busy, overrun, out_idx}, {1'b1, 1'b1, 1'b1, 1'b0, 5'd0});
    chk("b2b_row0", flat_out(), {16{8'h21}});
    wait_done("b2b_done");
    chk("b2b_end", {overrun, busy}, {1'b0, 1'b0});
    chk("b2b_sb_empty", 128'(exp_q.size()), 128'd0);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
